dmem_host_seq: RTL and testbench

Host-side run sequencer sitting directly upstream of the 9-bit processor core. It preloads a window of data memory from a byte stream while the core is held in reset, then releases the core and times the run until the core raises `done`. It then streams a result window of data memory back out. While the core is in reset, it owns the data-memory port through the top-level write/address mux.

---
 rtl/dmem_host_seq_pkg.sv | 26 ++
 rtl/dmem_host_seq_if.sv | 40 ++++
 rtl/dmem_host_seq_run_cycle_ctr.sv | 51 +++++
 rtl/dmem_host_seq.sv | 156 +++++++++++++++
 tb/tb_dmem_host_seq.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_host_seq_pkg.sv
// ----------------------------------------------------------------------------
// host_seq_pkg
//   Shared widths, sequencer state encoding and a small address helper for the
//   dmem_host_seq block (host-side load/run/unload sequencer).
//   No ports.
// ----------------------------------------------------------------------------
package host_seq_pkg;

   localparam int unsigned DM_AW = 8;    // data-memory address width
   localparam int unsigned DM_DW = 8;    // data-memory data width
   localparam int unsigned CYC_W = 16;   // run-cycle counter width

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_RUN    = 2'd2,
      ST_UNLOAD = 2'd3
   } host_state_t;

   // Window address: base plus byte index, wrapping modulo 2**DM_AW.
   function automatic logic [DM_AW-1:0] win_addr(input logic [DM_AW-1:0] base,
                                                 input logic [DM_AW-1:0] idx);
      return base + idx;
   endfunction

endpackage

// File: rtl/dmem_host_seq_if.sv
// ----------------------------------------------------------------------------
// dmem_host_seq_if
//   Bundles the load byte stream, the result byte stream and the host side of
//   the data-memory port used by dmem_host_seq.
//   master : the sequencer (accepts load bytes, emits result bytes, drives
//            the DMem write/address mux)
//   slave  : the environment (byte source/sink and the data memory)
//   Signals:
//     in_valid/in_data/in_ready    load byte stream
//     out_valid/out_data/out_ready result byte stream
//     dm_wen/dm_addr/dm_wdat       DMem write enable, address, write data
//     dm_rdat                      DMem combinational read data for dm_addr
// ----------------------------------------------------------------------------
interface dmem_host_seq_if;
   import host_seq_pkg::*;

   logic             in_valid;
   logic [DM_DW-1:0] in_data;
   logic             in_ready;

   logic             out_valid;
   logic [DM_DW-1:0] out_data;
   logic             out_ready;

   logic             dm_wen;
   logic [DM_AW-1:0] dm_addr;
   logic [DM_DW-1:0] dm_wdat;
   logic [DM_DW-1:0] dm_rdat;

   modport master (
      input  in_valid, in_data, out_ready, dm_rdat,
      output in_ready, out_valid, out_data, dm_wen, dm_addr, dm_wdat
   );

   modport slave (
      output in_valid, in_data, out_ready, dm_rdat,
      input  in_ready, out_valid, out_data, dm_wen, dm_addr, dm_wdat
   );

endinterface

// File: rtl/dmem_host_seq_run_cycle_ctr.sv
// ----------------------------------------------------------------------------
// run_cycle_ctr
//   Saturating run-cycle counter for dmem_host_seq.
//   Ports:
//     clk_i    clock
//     rst_ni   asynchronous active-low reset
//     clr_i    synchronous clear to zero (has priority over en_i)
//     en_i     count one cycle (saturates at all-ones)
//     count_o  current count
//     hit_o    high in the enabled cycle whose increment brings the count to
//              TIMEOUT, so the caller can act in that same cycle
// ----------------------------------------------------------------------------
module run_cycle_ctr
   import host_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CYC_W-1:0] count_o,
   output logic             hit_o
);

   localparam logic [CYC_W-1:0] HIT_AT = CYC_W'(TIMEOUT - 1);

   logic [CYC_W-1:0] count_q;
   logic [CYC_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign hit_o   = en_i && (count_q == HIT_AT);

endmodule

// File: rtl/dmem_host_seq.sv
// ----------------------------------------------------------------------------
// dmem_host_seq
//   Host-side run sequencer in front of the 9-bit core. On start it preloads a
//   DMem window from the load stream with the core held in reset, releases the
//   core and times the run until core_done, then streams a result window back
//   out. A run that reaches TIMEOUT cycles without core_done aborts to IDLE
//   with the sticky timeout_err flag set.
//   Ports:
//     clk          clock, all state on posedge
//     reset        asynchronous active-low reset
//     start        one-cycle sequence request (honoured only in IDLE)
//     bus          dmem_host_seq_if.master: load/result streams and DMem port
//     core_reset   active-high core reset, low only while running
//     core_done    core completion, sampled only while running
//     busy         high outside IDLE
//     timeout_err  sticky run-abort flag, cleared by an accepted start
//     cycle_count  run cycles of the last run (saturating)
// ----------------------------------------------------------------------------
module dmem_host_seq
   import host_seq_pkg::*;
#(
   parameter int unsigned LOAD_BASE   = 0,
   parameter int unsigned LOAD_LEN    = 32,
   parameter int unsigned UNLOAD_BASE = 32,
   parameter int unsigned UNLOAD_LEN  = 32,
   parameter int unsigned TIMEOUT     = 4096
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   dmem_host_seq_if.master  bus,
   output logic             core_reset,
   input  logic             core_done,
   output logic             busy,
   output logic             timeout_err,
   output logic [CYC_W-1:0] cycle_count
);

   localparam logic [DM_AW-1:0] LOAD_BASE_A   = DM_AW'(LOAD_BASE);
   localparam logic [DM_AW-1:0] UNLOAD_BASE_A = DM_AW'(UNLOAD_BASE);
   // Index of the final byte in each window; LOAD_LEN=0 never enters LOAD.
   localparam logic [DM_AW-1:0] LOAD_LAST     =
      DM_AW'((LOAD_LEN == 0) ? 0 : LOAD_LEN - 1);
   localparam logic [DM_AW-1:0] UNLOAD_LAST   = DM_AW'(UNLOAD_LEN - 1);

   host_state_t      state_q, state_d;
   logic [DM_AW-1:0] idx_q, idx_d;
   logic             terr_q, terr_d;

   logic             ctr_clr;
   logic             ctr_en;
   logic             ctr_hit;
   logic             load_hs;
   logic             unload_hs;

   assign load_hs   = (state_q == ST_LOAD)   && bus.in_valid;
   assign unload_hs = (state_q == ST_UNLOAD) && bus.out_ready;

   run_cycle_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_run_cycle_ctr (
      .clk_i   (clk),
      .rst_ni  (reset),
      .clr_i   (ctr_clr),
      .en_i    (ctr_en),
      .count_o (cycle_count),
      .hit_o   (ctr_hit)
   );

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      terr_d  = terr_q;
      ctr_clr = 1'b0;
      ctr_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               terr_d  = 1'b0;
               ctr_clr = 1'b1;
               idx_d   = '0;
               state_d = (LOAD_LEN == 0) ? ST_RUN : ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (load_hs) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == LOAD_LAST) begin
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            ctr_en = 1'b1;
            // core_done is checked first so that done on the timeout cycle
            // still completes normally.
            if (core_done) begin
               idx_d   = '0;
               state_d = ST_UNLOAD;
            end else if (ctr_hit) begin
               terr_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         ST_UNLOAD: begin
            if (unload_hs) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == UNLOAD_LAST) begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         terr_q  <= terr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all decoded from the current state, so the write lands in the
   // handshake cycle and the unload address is held across stalls)
   // ------------------------------------------------------------------------
   assign bus.in_ready  = (state_q == ST_LOAD);
   assign bus.dm_wen    = load_hs;
   assign bus.dm_wdat   = load_hs ? bus.in_data : '0;
   assign bus.dm_addr   = (state_q == ST_LOAD)   ? win_addr(LOAD_BASE_A, idx_q)   :
                          (state_q == ST_UNLOAD) ? win_addr(UNLOAD_BASE_A, idx_q) :
                                                   '0;
   assign bus.out_valid = (state_q == ST_UNLOAD);
   assign bus.out_data  = (state_q == ST_UNLOAD) ? bus.dm_rdat : '0;

   assign core_reset    = (state_q != ST_RUN);
   assign busy          = (state_q != ST_IDLE);
   assign timeout_err   = terr_q;

endmodule

// File: tb/tb_dmem_host_seq.sv
// ----------------------------------------------------------------------------
// tb_dmem_host_seq
//   Directed bench for dmem_host_seq. Three instances cover the main
//   parameterisations: A (base 0, 4-byte windows, TIMEOUT 20), B (windows
//   starting at 254, wrapping), C (zero-length load, 1-byte unload at 7,
//   TIMEOUT 3). Each instance has its own behavioural DMem.
// ----------------------------------------------------------------------------
module tb_dmem_host_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic done_a  = 1'b0, done_b  = 1'b0, done_c  = 1'b0;
   logic crst_a, crst_b, crst_c;
   logic busy_a, busy_b, busy_c;
   logic terr_a, terr_b, terr_c;
   logic [15:0] cyc_a, cyc_b, cyc_c;

   int n_assert = 0;
   int n_fail   = 0;

   dmem_host_seq_if bus_a ();
   dmem_host_seq_if bus_b ();
   dmem_host_seq_if bus_c ();

   logic [7:0] mem_a [256] = '{default: 8'hEE};
   logic [7:0] mem_b [256] = '{default: 8'hEE};
   logic [7:0] mem_c [256] = '{default: 8'h5A};
   int wen_a = 0, wen_b = 0, wen_c = 0;

   always #5 clk = ~clk;

   dmem_host_seq #(
      .LOAD_BASE(0), .LOAD_LEN(4), .UNLOAD_BASE(0), .UNLOAD_LEN(4), .TIMEOUT(20)
   ) dut_a (
      .clk(clk), .reset(rst_n), .start(start_a), .bus(bus_a),
      .core_reset(crst_a), .core_done(done_a), .busy(busy_a),
      .timeout_err(terr_a), .cycle_count(cyc_a)
   );

   dmem_host_seq #(
      .LOAD_BASE(254), .LOAD_LEN(4), .UNLOAD_BASE(254), .UNLOAD_LEN(4), .TIMEOUT(20)
   ) dut_b (
      .clk(clk), .reset(rst_n), .start(start_b), .bus(bus_b),
      .core_reset(crst_b), .core_done(done_b), .busy(busy_b),
      .timeout_err(terr_b), .cycle_count(cyc_b)
   );

   dmem_host_seq #(
      .LOAD_BASE(0), .LOAD_LEN(0), .UNLOAD_BASE(7), .UNLOAD_LEN(1), .TIMEOUT(3)
   ) dut_c (
      .clk(clk), .reset(rst_n), .start(start_c), .bus(bus_c),
      .core_reset(crst_c), .core_done(done_c), .busy(busy_c),
      .timeout_err(terr_c), .cycle_count(cyc_c)
   );

   // Behavioural data memories: synchronous write, combinational read.
   always @(posedge clk) begin
      if (bus_a.dm_wen === 1'b1) begin
         mem_a[bus_a.dm_addr] <= bus_a.dm_wdat;
         wen_a <= wen_a + 1;
      end
      if (bus_b.dm_wen === 1'b1) begin
         mem_b[bus_b.dm_addr] <= bus_b.dm_wdat;
         wen_b <= wen_b + 1;
      end
      if (bus_c.dm_wen === 1'b1) begin
         mem_c[bus_c.dm_addr] <= bus_c.dm_wdat;
         wen_c <= wen_c + 1;
      end
   end

   assign bus_a.dm_rdat = mem_a[bus_a.dm_addr];
   assign bus_b.dm_rdat = mem_b[bus_b.dm_addr];
   assign bus_c.dm_rdat = mem_c[bus_c.dm_addr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] ld [4];
      logic [7:0] b_addr [4];
      logic       rdy [6];
      int         exp_idx [6];

      bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
      bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b0;

      // ---------------- reset values ----------------
      #1 rst_n = 1'b0;
      #2;
      chk("rst core_reset", crst_a, 1);
      chk("rst busy", busy_a, 0);
      chk("rst in_ready", bus_a.in_ready, 0);
      chk("rst out_valid", bus_a.out_valid, 0);
      chk("rst out_data", bus_a.out_data, 0);
      chk("rst dm_wen", bus_a.dm_wen, 0);
      chk("rst dm_addr", bus_a.dm_addr, 0);
      chk("rst dm_wdat", bus_a.dm_wdat, 0);
      chk("rst timeout_err", terr_a, 0);
      chk("rst cycle_count", cyc_a, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // ---------------- basic sequence with load gap ----------------
      ld = '{8'd11, 8'd22, 8'd33, 8'd44};
      start_a = 1'b1; step(); start_a = 1'b0;
      chk("load busy", busy_a, 1);
      chk("load in_ready", bus_a.in_ready, 1);
      chk("load core_reset", crst_a, 1);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            bus_a.in_valid = 1'b0; bus_a.in_data = 8'hFF; #1;
            chk("gap dm_wen", bus_a.dm_wen, 0);
            step();
         end
         bus_a.in_valid = 1'b1; bus_a.in_data = ld[i]; #1;
         chk("load dm_wen", bus_a.dm_wen, 1);
         chk("load dm_addr", bus_a.dm_addr, i);
         chk("load dm_wdat", bus_a.dm_wdat, ld[i]);
         step();
      end
      bus_a.in_valid = 1'b0;
      chk("run core_reset", crst_a, 0);
      chk("run in_ready", bus_a.in_ready, 0);
      chk("run dm_addr", bus_a.dm_addr, 0);
      chk("write count", wen_a, 4);
      chk("mem0", mem_a[0], 11);
      chk("mem3", mem_a[3], 44);
      repeat (9) step();
      chk("run cyc9", cyc_a, 9);
      done_a = 1'b1; step(); done_a = 1'b0;
      chk("unl out_valid", bus_a.out_valid, 1);
      chk("unl cycle_count", cyc_a, 10);
      chk("unl core_reset", crst_a, 1);
      chk("unl timeout_err", terr_a, 0);

      // unload with backpressure 1,0,0,1,1,1
      rdy     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_idx = '{0, 1, 1, 1, 2, 3};
      for (int c = 0; c < 6; c++) begin
         bus_a.out_ready = rdy[c]; #1;
         chk("bp out_valid", bus_a.out_valid, 1);
         chk("bp out_data", bus_a.out_data, ld[exp_idx[c]]);
         chk("bp dm_addr", bus_a.dm_addr, exp_idx[c]);
         step();
      end
      bus_a.out_ready = 1'b0;
      chk("end busy", busy_a, 0);
      chk("end out_valid", bus_a.out_valid, 0);
      chk("end dm_addr", bus_a.dm_addr, 0);
      chk("end cycle_count", cyc_a, 10);
      chk("end write count", wen_a, 4);

      // ---------------- timeout ----------------
      start_a = 1'b1; step(); start_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_a.in_valid = 1'b1; bus_a.in_data = 8'(i + 1); step();
      end
      bus_a.in_valid = 1'b0;
      repeat (19) step();
      chk("to cyc19 busy", busy_a, 1);
      chk("to cyc19 terr", terr_a, 0);
      chk("to cyc19 count", cyc_a, 19);
      step();
      chk("to timeout_err", terr_a, 1);
      chk("to busy", busy_a, 0);
      chk("to cycle_count", cyc_a, 20);
      chk("to out_valid", bus_a.out_valid, 0);
      chk("to core_reset", crst_a, 1);
      repeat (3) step();
      chk("to out_valid later", bus_a.out_valid, 0);
      chk("to terr sticky", terr_a, 1);
      start_a = 1'b1; step(); start_a = 1'b0;
      chk("restart terr clr", terr_a, 0);
      chk("restart cyc clr", cyc_a, 0);
      chk("restart busy", busy_a, 1);

      // ---------------- done on the timeout cycle ----------------
      for (int i = 0; i < 4; i++) begin
         bus_a.in_valid = 1'b1; bus_a.in_data = 8'(i + 5); step();
      end
      bus_a.in_valid = 1'b0;
      repeat (19) step();
      done_a = 1'b1; step(); done_a = 1'b0;
      chk("bnd out_valid", bus_a.out_valid, 1);
      chk("bnd timeout_err", terr_a, 0);
      chk("bnd cycle_count", cyc_a, 20);
      for (int i = 0; i < 4; i++) begin
         bus_a.out_ready = 1'b1; #1;
         chk("bnd out_data", bus_a.out_data, i + 5);
         step();
      end
      bus_a.out_ready = 1'b0;
      chk("bnd busy", busy_a, 0);

      // ---------------- reset mid-unload ----------------
      start_a = 1'b1; step(); start_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_a.in_valid = 1'b1; bus_a.in_data = 8'(8'hA1 + i); step();
      end
      bus_a.in_valid = 1'b0;
      repeat (2) step();
      done_a = 1'b1; step(); done_a = 1'b0;
      chk("mr cycle_count", cyc_a, 3);
      bus_a.out_ready = 1'b1; step(); step();
      bus_a.out_ready = 1'b0; #1;
      chk("mr third byte", bus_a.out_data, 8'hA3);
      rst_n = 1'b0; #1;
      chk("mr out_valid", bus_a.out_valid, 0);
      chk("mr core_reset", crst_a, 1);
      chk("mr busy", busy_a, 0);
      chk("mr cycle_count", cyc_a, 0);
      chk("mr dm_addr", bus_a.dm_addr, 0);
      step();
      rst_n = 1'b1;
      step();
      start_a = 1'b1; step(); start_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_a.in_valid = 1'b1; bus_a.in_data = 8'(8'h51 + i); #1;
         chk("rr dm_addr", bus_a.dm_addr, i);
         step();
      end
      bus_a.in_valid = 1'b0;
      repeat (4) step();
      done_a = 1'b1; step(); done_a = 1'b0;
      chk("rr cycle_count", cyc_a, 5);
      for (int i = 0; i < 4; i++) begin
         bus_a.out_ready = 1'b1; #1;
         chk("rr out_data", bus_a.out_data, 8'h51 + i);
         step();
      end
      bus_a.out_ready = 1'b0;
      chk("rr busy", busy_a, 0);

      // ---------------- address wrap (instance B) ----------------
      b_addr = '{8'd254, 8'd255, 8'd0, 8'd1};
      start_b = 1'b1; step(); start_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus_b.in_valid = 1'b1; bus_b.in_data = 8'(8'h10 + i); #1;
         chk("wrap ld addr", bus_b.dm_addr, b_addr[i]);
         step();
      end
      bus_b.in_valid = 1'b0;
      chk("wrap mem254", mem_b[254], 8'h10);
      chk("wrap mem1", mem_b[1], 8'h13);
      done_b = 1'b1; step(); done_b = 1'b0;
      chk("wrap cycle_count", cyc_b, 1);
      for (int i = 0; i < 4; i++) begin
         bus_b.out_ready = 1'b1; #1;
         chk("wrap ul addr", bus_b.dm_addr, b_addr[i]);
         chk("wrap ul data", bus_b.out_data, 8'h10 + i);
         step();
      end
      bus_b.out_ready = 1'b0;
      chk("wrap busy", busy_b, 0);

      // ---------------- zero-length load (instance C) ----------------
      bus_c.in_valid = 1'b1; bus_c.in_data = 8'h99;
      start_c = 1'b1; step(); start_c = 1'b0;
      chk("z0 core_reset", crst_c, 0);
      chk("z0 busy", busy_c, 1);
      chk("z0 in_ready", bus_c.in_ready, 0);
      chk("z0 dm_wen", bus_c.dm_wen, 0);
      step(); step();
      chk("z0 in_ready run", bus_c.in_ready, 0);
      chk("z0 terr before", terr_c, 0);
      step();
      chk("z0 timeout_err", terr_c, 1);
      chk("z0 cycle_count", cyc_c, 3);
      start_c = 1'b1; step(); start_c = 1'b0;
      chk("z0 terr clr", terr_c, 0);
      done_c = 1'b1; step(); done_c = 1'b0;
      chk("z0 out_valid", bus_c.out_valid, 1);
      chk("z0 ul addr", bus_c.dm_addr, 7);
      chk("z0 ul data", bus_c.out_data, 8'h5A);
      bus_c.out_ready = 1'b1; step(); bus_c.out_ready = 1'b0;
      chk("z0 end busy", busy_c, 0);
      chk("z0 end out_valid", bus_c.out_valid, 0);
      chk("z0 no writes", wen_c, 0);
      bus_c.in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
